// File: rtl/alu_insn_encoder_if.sv
// Request/response bundle for alu_insn_encoder: request side (in_*, operands)
// and buffered instruction side (out_*), plus the illegal-request pulse.
interface alu_insn_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_op;
    logic        use_imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [11:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_insn;
    logic        err_illegal;

    modport master (
        output in_valid, alu_op, use_imm, rd, rs1, rs2, imm, out_ready,
        input  in_ready, out_valid, out_insn, err_illegal
    );

    modport slave (
        input  in_valid, alu_op, use_imm, rd, rs1, rs2, imm, out_ready,
        output in_ready, out_valid, out_insn, err_illegal
    );
endinterface

// File: rtl/alu_insn_encoder.sv
// Encodes ALU op + operands into RV32I R/I-type words, buffered in a small FIFO.
// Optional saturating statistics counters when ALU_ENC_STATS_EN is defined.
module alu_insn_encoder #(
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 16
) (
    input  logic clk,
    input  logic rst_n,
    alu_insn_encoder_if.slave bus
`ifdef ALU_ENC_STATS_EN
    ,
    output logic [CNT_W-1:0] insn_cnt,
    output logic [CNT_W-1:0] err_cnt
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    localparam logic [6:0] OPC_R = 7'b0110011;
    localparam logic [6:0] OPC_I = 7'b0010011;

    logic [31:0] mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        err_q, err_d;

    logic        full, empty;
    logic        accept, push, pop;
    logic        illegal;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] insn;

    // Extra MSB distinguishes full from empty when the low bits match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign bus.in_ready    = !full;
    assign bus.out_valid   = !empty;
    assign bus.out_insn    = empty ? 32'h0 : mem_q[rd_ptr_q[AW-1:0]];
    assign bus.err_illegal = err_q;

    assign accept = bus.in_valid && !full;
    assign push   = accept && !illegal;
    assign pop    = !empty && bus.out_ready;

    always_comb begin
        funct3  = 3'b000;
        funct7  = 7'b0000000;
        illegal = 1'b0;
        case (bus.alu_op)
            4'd0:    funct3 = 3'b000;
            4'd1:    funct7 = 7'b0100000;
            4'd2:    funct3 = 3'b111;
            4'd3:    funct3 = 3'b110;
            4'd4:    funct3 = 3'b100;
            default: illegal = 1'b1;
        endcase
        // There is no SUBI in RV32I.
        if (bus.alu_op == 4'd1 && bus.use_imm)
            illegal = 1'b1;
        if (bus.use_imm)
            insn = {bus.imm, bus.rs1, funct3, bus.rd, OPC_I};
        else
            insn = {funct7, bus.rs2, bus.rs1, funct3, bus.rd, OPC_R};
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        err_d    = accept && illegal;
        if (push)
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)
            rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem_q[i] <= 32'h0;
        end else if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= insn;
        end
    end

`ifdef ALU_ENC_STATS_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] insn_cnt_q, insn_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        insn_cnt_d = insn_cnt_q;
        err_cnt_d  = err_cnt_q;
        if (push && insn_cnt_q != '1)
            insn_cnt_d = insn_cnt_q + CNT_ONE;
        if (accept && illegal && err_cnt_q != '1)
            err_cnt_d = err_cnt_q + CNT_ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            insn_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            insn_cnt_q <= insn_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign insn_cnt = insn_cnt_q;
    assign err_cnt  = err_cnt_q;
`endif

endmodule

// File: tb/tb_alu_insn_encoder.sv
// Directed table-driven bench for alu_insn_encoder plus hand sequences for
// back-pressure, push+pop, and mid-operation reset.
module tb_alu_insn_encoder;

    localparam int CW = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_insn_encoder_if bus_if();

`ifdef ALU_ENC_STATS_EN
    logic [CW-1:0] insn_cnt, err_cnt;
`endif

    alu_insn_encoder #(.FIFO_DEPTH(2), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
`ifdef ALU_ENC_STATS_EN
        ,
        .insn_cnt (insn_cnt),
        .err_cnt  (err_cnt)
`endif
    );

    typedef struct {
        logic [3:0]  op;
        logic        ui;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [11:0] imm;
        logic        ill;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];
    int checks = 0;
    int failures = 0;
    int exp_insn = 0;
    int exp_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic int sat(input int x);
        return (x > (1 << CW) - 1) ? (1 << CW) - 1 : x;
    endfunction

    task automatic chk_stats(input string name);
`ifdef ALU_ENC_STATS_EN
        chk({name, "_insn_cnt"}, 32'(insn_cnt), exp_insn);
        chk({name, "_err_cnt"}, 32'(err_cnt), exp_err);
`else
        if (name.len() < 0) $display("%s", name);
`endif
    endtask

    task automatic drive(input vec_t v);
        bus_if.in_valid = 1'b1;
        bus_if.alu_op   = v.op;
        bus_if.use_imm  = v.ui;
        bus_if.rd       = v.rd;
        bus_if.rs1      = v.rs1;
        bus_if.rs2      = v.rs2;
        bus_if.imm      = v.imm;
    endtask

    task automatic note_accept(input vec_t v);
        if (v.ill) exp_err = sat(exp_err + 1);
        else       exp_insn = sat(exp_insn + 1);
    endtask

    initial begin
        //           op    ui  rd  rs1 rs2 imm      ill  expected word
        vecs[0] = '{4'd0, 0,   3,  1,  2,  12'h000, 0, 32'h002081B3}; // add x3,x1,x2
        vecs[1] = '{4'd1, 0,   5,  6,  7,  12'h000, 0, 32'h407302B3}; // sub x5,x6,x7
        vecs[2] = '{4'd0, 1,   1,  0,  5,  12'hFFF, 0, 32'hFFF00093}; // addi, rs2 ignored
        vecs[3] = '{4'd2, 1,   2,  2,  0,  12'h0FF, 0, 32'h0FF17113}; // andi
        vecs[4] = '{4'd3, 0,  10, 11, 12,  12'h000, 0, 32'h00C5E533}; // or
        vecs[5] = '{4'd4, 1,  31, 31,  0,  12'h800, 0, 32'h800FCF93}; // xori
        vecs[6] = '{4'd2, 0,   1,  2,  3,  12'hABC, 0, 32'h003170B3}; // and, imm ignored
        vecs[7] = '{4'd1, 1,   4,  4,  0,  12'h001, 1, 32'h00000000}; // subi illegal
        vecs[8] = '{4'd15, 0,  4,  4,  4,  12'h000, 1, 32'h00000000};
        vecs[9] = '{4'd5, 0,   4,  4,  4,  12'h000, 1, 32'h00000000};

        bus_if.in_valid  = 1'b0;
        bus_if.alu_op    = '0;
        bus_if.use_imm   = 1'b0;
        bus_if.rd        = '0;
        bus_if.rs1       = '0;
        bus_if.rs2       = '0;
        bus_if.imm       = '0;
        bus_if.out_ready = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_out_valid", bus_if.out_valid, 0);
        chk("rst_out_insn", bus_if.out_insn, 0);
        chk("rst_err", bus_if.err_illegal, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", bus_if.in_ready, 1);
        chk_stats("rst");

        // Table: one request at a time, check one cycle after accept, then drain.
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i]);
            chk($sformatf("v%0d_in_ready", i), bus_if.in_ready, 1);
            @(posedge clk);
            note_accept(vecs[i]);
            @(negedge clk);
            bus_if.in_valid = 1'b0;
            chk($sformatf("v%0d_out_valid", i), bus_if.out_valid, !vecs[i].ill);
            chk($sformatf("v%0d_err", i), bus_if.err_illegal, vecs[i].ill);
            if (!vecs[i].ill)
                chk($sformatf("v%0d_insn", i), bus_if.out_insn, vecs[i].exp);
            bus_if.out_ready = !vecs[i].ill;
            @(negedge clk);
            bus_if.out_ready = 1'b0;
            chk($sformatf("v%0d_drained", i), bus_if.out_valid, 0);
            chk($sformatf("v%0d_err_pulse", i), bus_if.err_illegal, 0);
        end
        chk_stats("table");

        // Back-pressure: three requests into a 2-deep FIFO.
        drive(vecs[0]);
        @(posedge clk); note_accept(vecs[0]);
        @(negedge clk);
        drive(vecs[1]);
        chk("bp_ready1", bus_if.in_ready, 1);
        chk("bp_head_a", bus_if.out_insn, vecs[0].exp);
        @(posedge clk); note_accept(vecs[1]);
        @(negedge clk);
        drive(vecs[4]);
        chk("bp_full", bus_if.in_ready, 0);
        @(negedge clk);
        chk("bp_still_full", bus_if.in_ready, 0);
        chk("bp_hold_a", bus_if.out_insn, vecs[0].exp);
        bus_if.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_head_b", bus_if.out_insn, vecs[1].exp);
        chk("bp_ready2", bus_if.in_ready, 1);
        @(posedge clk); note_accept(vecs[4]);
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        chk("bp_head_c_valid", bus_if.out_valid, 1);
        chk("bp_head_c", bus_if.out_insn, vecs[4].exp);
        @(negedge clk);
        bus_if.out_ready = 1'b0;
        chk("bp_empty", bus_if.out_valid, 0);
        chk_stats("bp");

        // Push and pop together with one entry queued.
        drive(vecs[3]);
        @(posedge clk); note_accept(vecs[3]);
        @(negedge clk);
        drive(vecs[5]);
        bus_if.out_ready = 1'b1;
        chk("pp_head_a", bus_if.out_insn, vecs[3].exp);
        @(posedge clk); note_accept(vecs[5]);
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        chk("pp_valid", bus_if.out_valid, 1);
        chk("pp_head_b", bus_if.out_insn, vecs[5].exp);
        @(negedge clk);
        bus_if.out_ready = 1'b0;
        chk("pp_occ_one", bus_if.out_valid, 0);

        // Reset with two entries queued.
        drive(vecs[0]);
        @(posedge clk); note_accept(vecs[0]);
        @(negedge clk);
        drive(vecs[1]);
        @(posedge clk); note_accept(vecs[1]);
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        chk("rs_pre_full", bus_if.in_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        exp_insn = 0;
        exp_err = 0;
        chk("rs_out_valid", bus_if.out_valid, 0);
        chk("rs_out_insn", bus_if.out_insn, 0);
        chk_stats("rs");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rs_after_valid", bus_if.out_valid, 0);
        chk("rs_after_ready", bus_if.in_ready, 1);
        drive(vecs[6]);
        @(posedge clk); note_accept(vecs[6]);
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        chk("rs_new_head", bus_if.out_insn, vecs[6].exp);
        bus_if.out_ready = 1'b1;
        @(negedge clk);
        bus_if.out_ready = 1'b0;
        chk("rs_new_drained", bus_if.out_valid, 0);

        // Reset kills a pending err_illegal pulse.
        drive(vecs[8]);
        @(posedge clk); note_accept(vecs[8]);
        #1;
        bus_if.in_valid = 1'b0;
        chk("re_err_set", bus_if.err_illegal, 1);
        rst_n = 1'b0;
        #1;
        exp_insn = 0;
        exp_err = 0;
        chk("re_err_clr", bus_if.err_illegal, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("re_err_after", bus_if.err_illegal, 0);
        chk("re_valid_after", bus_if.out_valid, 0);
        chk_stats("re");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
